boot_loader: RTL and testbench
==============================

# boot_loader

Streams a program image from a byte source into the CPU's boot port and holds the CPU in debug while loading. It parses a little-endian length header, then packs data bytes into 32-bit words and writes them to consecutive word addresses. A trailing XOR checksum is then verified, and the CPU is released only if the check passes. It sits between the host byte link (UART RX or testbench) and the CPU's `boot_addr`/`boot_data`/`debug` inputs.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first image word.
- `MAX_WORDS`, default 16384: largest accepted word count. A larger count is an error.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain only.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `rx_valid && rx_ready`.
- `boot_we`  out  1  one-cycle write strobe to CPU instruction memory.
- `boot_addr`  out  32  byte address for the write, word aligned.
- `boot_data`  out  32  word for the write.
- `debug`  out  1  holds the CPU stalled. High from reset until `DONE`.
- `done`  out  1  image loaded and verified. Sticky until reset.
- `error`  out  1  length overflow or checksum mismatch. Sticky until reset.

## Operation
- Reset values: `rx_ready`=1, `boot_we`=0, `boot_addr`=`BASE_ADDR`, `boot_data`=0, `debug`=1, `done`=0, `error`=0. State is `LEN` and all counters are 0.
- `LEN`: accepts 4 bytes, little-endian, as the word count N.
  - If N > `MAX_WORDS`, go to `ERR`.
  - If N == 0, go to `CSUM`.
  - Otherwise go to `DATA`.
- `DATA`: accepts bytes, least significant first, into a 32-bit shift/pack register.
  - Every data byte is XORed into an 8-bit running checksum.
  - On the 4th byte of a word: register `boot_data` = packed word and `boot_addr` = `BASE_ADDR` + 4·word_idx, pulse `boot_we`, then increment word_idx.
  - After word N−1 is written, go to `CSUM`.
- `CSUM`: accepts 1 byte.
  - If it equals the running XOR, go to `DONE`.
  - Otherwise go to `ERR`.
- `DONE`: `rx_ready`=0, `debug`=0, `done`=1. Terminal until reset.
- `ERR`: `rx_ready`=0, `debug`=1, `error`=1. Terminal until reset.
- Cycles with `rx_valid`=0 leave all state unchanged. No bytes are lost or duplicated.
- Width rules: word_idx is `$clog2(MAX_WORDS+1)` bits. `boot_addr` arithmetic is 32-bit and wraps modulo 2^32. Header and checksum bytes are excluded from the XOR.
- Asserting reset at any point aborts the load: all outputs return to reset values within the reset assertion and partial words are discarded.

## Timing
- `rx_ready` is combinational from state. It is 1 in `LEN`/`DATA`/`CSUM`, with no backpressure mid-image, so bytes may arrive on every cycle.
- `boot_we`, `boot_addr` and `boot_data` are registered. They are valid in the cycle after the 4th byte of a word is accepted. `boot_we` is high for exactly 1 cycle per word.
- Back-to-back full-rate input gives one write every 4 cycles, so strobes never overlap.
- `done` rises and `debug` falls in the cycle after the checksum byte is accepted. The last `boot_we` precedes this by at least 1 cycle.
- `error` rises in the cycle after the offending header byte or checksum byte is accepted.

## Structure
- Shared package `boot_pkg`:
  - `boot_state_t` enum {`LEN`, `DATA`, `CSUM`, `DONE`, `ERR`}.
  - `BOOT_HDR_BYTES`=4.
  - `BOOT_WORD_BYTES`=4.
- Sub-module `byte_packer` holds the 2-bit byte lane counter and the 32-bit assembly register. It takes a byte plus a strobe and outputs `word`/`word_valid`, and is reused for both the header and the data. The loader top holds the FSM, word_idx, the XOR accumulator and the output registers.

## Test plan
- Stream 02 00 00 00 EF BE AD DE 13 00 00 00 31 at full rate.
  - Expect exactly two `boot_we` pulses: (0x0, 0xDEADBEEF) then (0x4, 0x00000013).
  - Then `done`=1 and `debug`=0, with `error` staying 0.
- Same stream with a checksum of 0x30: expect both writes, then `error`=1, `debug`=1, `done`=0 and `rx_ready`=0.
- Stream 00 00 00 00 00: expect no writes and `done`=1 one cycle after the last byte.
- Header 01 40 00 00 (N=16385, with `MAX_WORDS`=16384): expect `error`=1 after the 4th byte and no writes.
- First stream with random `rx_valid` gaps of 0–5 cycles: expect an identical write sequence and final state.
- Pulse `rst_n` low after byte 6 of the first stream, then resend the whole stream: expect all outputs at reset values during reset and only the correct two writes and `done` afterwards.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader.
//   boot_state_t    : loader FSM states
//   BOOT_HDR_BYTES  : bytes in the little-endian word-count header
//   BOOT_WORD_BYTES : bytes packed into one image word
package boot_pkg;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } boot_state_t;

    localparam int BOOT_HDR_BYTES  = 4;
    localparam int BOOT_WORD_BYTES = 4;

endpackage

// File: rtl/boot_loader_if.sv
// Byte link plus CPU boot port of the boot loader.
//   rx_data/rx_valid/rx_ready : host byte stream into the loader
//   boot_we/boot_addr/boot_data : word writes to CPU instruction memory
//   debug/done/error : CPU stall and load status
//
// Handshake: a byte transfers on every rising clock edge where
// rx_valid && rx_ready. The source may assert rx_valid independently of
// rx_ready and must hold rx_data stable while rx_valid is high and the
// byte has not yet transferred. rx_ready depends only on loader state,
// never on rx_valid.
interface boot_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_we;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        debug;
    logic        done;
    logic        error;

    // Host / CPU side.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, boot_we, boot_addr, boot_data, debug, done, error
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, boot_we, boot_addr, boot_data, debug, done, error
    );

endinterface

// File: rtl/byte_packer.sv
// Packs bytes, least significant first, into 32-bit words.
//   clk, rst_n   : clock, async active-low reset
//   byte_i       : incoming byte
//   strobe_i     : byte_i is consumed this cycle
//   word_o       : assembled word including the current byte
//   word_valid_o : strobe_i carries the 4th byte of a word (combinational)
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        strobe_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] asm_q, asm_d;

    // The word is presented in the same cycle as its last byte so the
    // consumer can register it without an extra pipeline stage.
    always_comb begin
        asm_d  = asm_q;
        lane_d = lane_q;
        if (strobe_i) begin
            asm_d[lane_q*8 +: 8] = byte_i;
            // 2-bit counter wraps to lane 0 after the 4th byte.
            lane_d = lane_q + 2'd1;
        end
    end

    assign word_o       = asm_d;
    assign word_valid_o = strobe_i && (lane_q == 2'(BOOT_WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            asm_q  <= 32'd0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed program image from a byte link into CPU
// instruction memory, verifies a trailing XOR checksum and then releases
// the CPU from debug.
//   clk, rst_n : clock, async active-low reset
//   bus        : byte link and CPU boot port (slave side)
//   state_o    : current FSM state, for observation
// Parameters:
//   BASE_ADDR  : byte address of the first image word
//   MAX_WORDS  : largest accepted word count
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic         clk,
    input  logic         rst_n,
    boot_loader_if.slave bus,
    output boot_state_t  state_o
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_WORDS_32 = 32'(MAX_WORDS);

    boot_state_t      state_q, state_d;
    logic [IDX_W-1:0] n_words_q, n_words_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]       xor_q, xor_d;
    logic             boot_we_q, boot_we_d;
    logic [31:0]      boot_addr_q, boot_addr_d;
    logic [31:0]      boot_data_q, boot_data_d;

    logic             rx_ready;
    logic             accept;
    logic             pack_strobe;
    logic [31:0]      pack_word;
    logic             pack_word_valid;
    logic [31:0]      word_offset;

    assign rx_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign accept   = bus.rx_valid && rx_ready;

    // The packer serves the header first and then the data; it is left on
    // lane 0 after the 4-byte header, so data words start aligned.
    assign pack_strobe = accept && ((state_q == LEN) || (state_q == DATA));

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_i       (bus.rx_data),
        .strobe_i     (pack_strobe),
        .word_o       (pack_word),
        .word_valid_o (pack_word_valid)
    );

    // Byte offset of the current word; the add below wraps modulo 2^32.
    assign word_offset = {{(32 - IDX_W){1'b0}}, word_idx_q} << 2;

    always_comb begin
        state_d     = state_q;
        n_words_d   = n_words_q;
        word_idx_d  = word_idx_q;
        xor_d       = xor_q;
        boot_we_d   = 1'b0;
        boot_addr_d = boot_addr_q;
        boot_data_d = boot_data_q;

        case (state_q)
            LEN: begin
                if (pack_word_valid) begin
                    if (pack_word > MAX_WORDS_32) begin
                        state_d = ERR;
                    end else if (pack_word == 32'd0) begin
                        state_d = CSUM;
                    end else begin
                        // Fits in IDX_W bits because it is <= MAX_WORDS.
                        n_words_d = pack_word[IDX_W-1:0];
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ bus.rx_data;
                end
                if (pack_word_valid) begin
                    boot_we_d   = 1'b1;
                    boot_data_d = pack_word;
                    boot_addr_d = BASE_ADDR + word_offset;
                    word_idx_d  = word_idx_q + IDX_W'(1);
                    if (word_idx_q == n_words_q - IDX_W'(1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data == xor_q) ? DONE : ERR;
                end
            end
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LEN;
            n_words_q   <= '0;
            word_idx_q  <= '0;
            xor_q       <= 8'd0;
            boot_we_q   <= 1'b0;
            boot_addr_q <= BASE_ADDR;
            boot_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            n_words_q   <= n_words_d;
            word_idx_q  <= word_idx_d;
            xor_q       <= xor_d;
            boot_we_q   <= boot_we_d;
            boot_addr_q <= boot_addr_d;
            boot_data_q <= boot_data_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.boot_we   = boot_we_q;
    assign bus.boot_addr = boot_addr_q;
    assign bus.boot_data = boot_data_q;
    assign bus.debug     = (state_q != DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.error     = (state_q == ERR);
    assign state_o       = state_q;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;
    import boot_pkg::*;

    logic        clk;
    logic        rst_n;
    boot_state_t state;

    boot_loader_if bus();

    boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (16384)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];   // {addr, data}
    logic [63:0] obs_q[$];

    // Writes are captured once per cycle, so a strobe held longer than one
    // cycle shows up as an extra entry.
    always @(negedge clk) begin
        if (rst_n && bus.boot_we === 1'b1) obs_q.push_back({bus.boot_addr, bus.boot_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_q[i][63:32], exp_q[i][63:32]);
            check($sformatf("%s_data%0d", tag, i), obs_q[i][31:0],  exp_q[i][31:0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},  32'(bus.rx_ready), 32'd1);
        check({tag, "_boot_we"},   32'(bus.boot_we), 32'd0);
        check({tag, "_boot_addr"}, bus.boot_addr, 32'h0);
        check({tag, "_boot_data"}, bus.boot_data, 32'h0);
        check({tag, "_debug"},     32'(bus.debug), 32'd1);
        check({tag, "_done"},      32'(bus.done), 32'd0);
        check({tag, "_error"},     32'(bus.error), 32'd0);
        check({tag, "_state"},     32'(state), 32'(LEN));
    endtask

    // ---------------- drivers ----------------
    logic [7:0] stim[$];

    // Entered and left at #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int max_gap);
        foreach (stim[i]) send_byte(stim[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic load_first_stream(input logic [7:0] csum);
        stim = '{8'h02, 8'h00, 8'h00, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'h13, 8'h00, 8'h00, 8'h00, csum};
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2;
        apply_reset();

        // 1: good two-word image at full rate
        load_first_stream(8'h31);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        exp_q.push_back({32'h4, 32'h00000013});
        for (int i = 0; i < 12; i++) send_byte(stim[i], 0);
        check("good_pre_csum_done", 32'(bus.done), 32'd0);
        check("good_pre_csum_state", 32'(state), 32'(CSUM));
        send_byte(stim[12], 0);
        check("good_done", 32'(bus.done), 32'd1);
        check("good_debug", 32'(bus.debug), 32'd0);
        check("good_error", 32'(bus.error), 32'd0);
        check("good_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_writes("good");

        // 2: bad checksum
        apply_reset();
        load_first_stream(8'h30);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        exp_q.push_back({32'h4, 32'h00000013});
        send_stim(0);
        check("badcs_error", 32'(bus.error), 32'd1);
        check("badcs_debug", 32'(bus.debug), 32'd1);
        check("badcs_done", 32'(bus.done), 32'd0);
        check("badcs_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("badcs");

        // 3: empty image
        apply_reset();
        stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
        check("empty_state_csum", 32'(state), 32'(CSUM));
        send_byte(stim[4], 0);
        check("empty_done", 32'(bus.done), 32'd1);
        check("empty_debug", 32'(bus.debug), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("empty");

        // 4: length overflow (N = 16385)
        apply_reset();
        stim = '{8'h01, 8'h40, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) send_byte(stim[i], 0);
        check("ovf_error_early", 32'(bus.error), 32'd0);
        send_byte(stim[3], 0);
        check("ovf_error", 32'(bus.error), 32'd1);
        check("ovf_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("ovf_debug", 32'(bus.debug), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_writes("ovf");

        // 4b: N == MAX_WORDS header is accepted
        apply_reset();
        stim = '{8'h00, 8'h40, 8'h00, 8'h00};
        send_stim(0);
        check("maxn_state", 32'(state), 32'(DATA));
        check("maxn_error", 32'(bus.error), 32'd0);

        // 5: good image with random idle gaps
        apply_reset();
        load_first_stream(8'h31);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        exp_q.push_back({32'h4, 32'h00000013});
        send_stim(5);
        check("gap_done", 32'(bus.done), 32'd1);
        check("gap_debug", 32'(bus.debug), 32'd0);
        check("gap_error", 32'(bus.error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("gap");

        // 6: reset after byte 6, then resend the full image
        apply_reset();
        load_first_stream(8'h31);
        for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
        check("abort_state_data", 32'(state), 32'(DATA));
        apply_reset();
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        exp_q.push_back({32'h4, 32'h00000013});
        send_stim(0);
        check("abort_done", 32'(bus.done), 32'd1);
        check("abort_error", 32'(bus.error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
